// File: rtl/cq_ctrl_pkg.sv
// Shared constants and types for the 8-entry circular queue (datapath and controller).
package cq_ctrl_pkg;
    localparam int PTR_W = 3;
    localparam int DEPTH = 2 ** PTR_W;
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/cq_ctrl_if.sv
// Push/pop handshake plus pointer/occupancy status between the queue users and cq_ctrl.
interface cq_ctrl_if;
    import cq_ctrl_pkg::*;

    logic push;
    logic pop;
    logic wr_en;
    ptr_t wr_addr;
    ptr_t rd_addr;
    cnt_t count;
    logic full;
    logic empty;
    logic err;

    // Producer/consumer side: issues requests, observes status.
    modport master (
        output push, pop,
        input  wr_en, wr_addr, rd_addr, count, full, empty, err
    );

    // Controller side.
    modport slave (
        input  push, pop,
        output wr_en, wr_addr, rd_addr, count, full, empty, err
    );
endinterface

// File: rtl/cq_ptr.sv
// Wrapping PTR_W-bit pointer: synchronous reset, increment when en is high.
// The increment is a half-adder ripple with en injected as the carry-in,
// so the natural overflow gives the 7 -> 0 wrap with no special case.
module cq_ptr
    import cq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    output ptr_t ptr
);
    ptr_t ptr_reg;
    ptr_t ptr_next;
    ptr_t carry;

    assign carry[0] = en;

    generate
        for (genvar gi = 0; gi < PTR_W; gi++) begin : g_inc
            assign ptr_next[gi] = ptr_reg[gi] ^ carry[gi];
            if (gi < PTR_W - 1) begin : g_carry
                assign carry[gi+1] = ptr_reg[gi] & carry[gi];
            end
        end
    endgenerate

    // Pointer register; carry-in of zero leaves the value unchanged.
    always_ff @(posedge clk) begin
        if (reset) ptr_reg <= '0;
        else       ptr_reg <= ptr_next;
    end

    assign ptr = ptr_reg;
endmodule

// File: rtl/cq_ctrl.sv
// Circular-queue pointer/occupancy controller.
// Optional feature: define CQ_CTRL_ERR_EN to build the sticky overflow/underflow err flag;
// otherwise err is tied low.
module cq_ctrl
    import cq_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    cq_ctrl_if.slave  q
);
    cnt_t count_reg;
    cnt_t count_next;
    cnt_t delta;
    cnt_t carry;
    logic full;
    logic empty;
    logic push_ok;
    logic pop_ok;

    // Status flags come only from the registered count, so they are glitch-free.
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // A push into a full queue is accepted when a pop frees the head slot in the same cycle.
    assign push_ok = q.push & (~full | q.pop);
    assign pop_ok  = q.pop & ~empty;

    // Delta of +1, -1 (all ones) or 0 for the occupancy add/subtract chain.
    always_comb begin
        delta = '0;
        if (push_ok && !pop_ok)      delta = CNT_W'(1);
        else if (pop_ok && !push_ok) delta = '1;
    end

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < CNT_W; gi++) begin : g_cnt_add
            assign count_next[gi] = count_reg[gi] ^ delta[gi] ^ carry[gi];
            if (gi < CNT_W - 1) begin : g_carry
                assign carry[gi+1] = (count_reg[gi] & delta[gi]) |
                                     (carry[gi] & (count_reg[gi] ^ delta[gi]));
            end
        end
    endgenerate

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) count_reg <= '0;
        else       count_reg <= count_next;
    end

    cq_ptr u_tail (
        .clk   (clk),
        .reset (reset),
        .en    (push_ok),
        .ptr   (q.wr_addr)
    );

    cq_ptr u_head (
        .clk   (clk),
        .reset (reset),
        .en    (pop_ok),
        .ptr   (q.rd_addr)
    );

`ifdef CQ_CTRL_ERR_EN
    logic err_reg;

    // Sticky misuse flag: overflow attempt (push into full without pop) or underflow attempt.
    always_ff @(posedge clk) begin
        if (reset) err_reg <= 1'b0;
        else       err_reg <= err_reg | (q.push & full & ~q.pop) | (q.pop & empty);
    end

    assign q.err = err_reg;
`else
    assign q.err = 1'b0;
`endif

    // The write strobe is held low while reset is asserted, since reset wins over any push.
    assign q.wr_en = push_ok & ~reset;
    assign q.count = count_reg;
    assign q.full  = full;
    assign q.empty = empty;
endmodule

// File: tb/tb_cq_ctrl.sv
// Directed self-checking bench for cq_ctrl.
module tb_cq_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

`ifdef CQ_CTRL_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    cq_ctrl_if q_if ();

    cq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .q     (q_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int rd, input int wr, input int cnt,
                             input logic f, input logic e, input logic er);
        chk({tag, ".rd_addr"}, 32'(q_if.rd_addr), 32'(rd));
        chk({tag, ".wr_addr"}, 32'(q_if.wr_addr), 32'(wr));
        chk({tag, ".count"},   32'(q_if.count),   32'(cnt));
        chk({tag, ".full"},    32'(q_if.full),    32'(f));
        chk({tag, ".empty"},   32'(q_if.empty),   32'(e));
        chk({tag, ".err"},     32'(q_if.err),     32'(er));
        $display("step %s: rd=%0d wr=%0d count=%0d full=%0d empty=%0d err=%0d",
                 tag, q_if.rd_addr, q_if.wr_addr, q_if.count, q_if.full, q_if.empty, q_if.err);
    endtask

    // Apply one cycle of push/pop, check the same-cycle strobe, then step past the edge.
    task automatic cyc(input string tag, input logic p, input logic o, input logic exp_wr_en);
        q_if.push = p;
        q_if.pop  = o;
        #1;
        chk({tag, ".wr_en"}, 32'(q_if.wr_en), 32'(exp_wr_en));
        @(posedge clk);
        #1;
        q_if.push = 1'b0;
        q_if.pop  = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        q_if.push = 1'b0;
        q_if.pop  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_state("reset", 0, 0, 0, 1'b0, 1'b1, 1'b0);
        cyc("idle", 1'b0, 1'b0, 1'b0);
        chk_state("idle", 0, 0, 0, 1'b0, 1'b1, 1'b0);

        // Fill from empty.
        for (int i = 0; i < 8; i++) begin
            chk("fill.wr_addr", 32'(q_if.wr_addr), 32'(i));
            cyc("fill", 1'b1, 1'b0, 1'b1);
            chk("fill.count", 32'(q_if.count), 32'(i + 1));
            chk("fill.full", 32'(q_if.full), 32'(i == 7));
            $display("fill %0d: count=%0d full=%0d", i, q_if.count, q_if.full);
        end
        cyc("overflow", 1'b1, 1'b0, 1'b0);
        chk_state("overflow", 0, 0, 8, 1'b1, 1'b0, EXP_ERR);

        // Drain; head wraps 7 -> 0.
        for (int i = 0; i < 8; i++) begin
            chk("drain.rd_addr", 32'(q_if.rd_addr), 32'(i));
            cyc("drain", 1'b0, 1'b1, 1'b0);
            chk("drain.count", 32'(q_if.count), 32'(7 - i));
            $display("drain %0d: count=%0d rd=%0d", i, q_if.count, q_if.rd_addr);
        end
        chk_state("drained", 0, 0, 0, 1'b0, 1'b1, EXP_ERR);
        cyc("underflow", 1'b0, 1'b1, 1'b0);
        chk_state("underflow", 0, 0, 0, 1'b0, 1'b1, EXP_ERR);

        // 3 pushes, then 10 simultaneous push+pop.
        for (int i = 0; i < 3; i++) cyc("pre3", 1'b1, 1'b0, 1'b1);
        chk_state("pre3", 0, 3, 3, 1'b0, 1'b0, EXP_ERR);
        for (int i = 0; i < 10; i++) cyc("pp", 1'b1, 1'b1, 1'b1);
        chk_state("pp10", 2, 5, 3, 1'b0, 1'b0, EXP_ERR);

        // Refill to full, then push+pop while full.
        for (int i = 0; i < 5; i++) cyc("refill", 1'b1, 1'b0, 1'b1);
        chk_state("refill", 2, 2, 8, 1'b1, 1'b0, EXP_ERR);
        cyc("full_pp", 1'b1, 1'b1, 1'b1);
        chk_state("full_pp", 3, 3, 8, 1'b1, 1'b0, EXP_ERR);

        // Drain, then push+pop while empty: pop ignored.
        for (int i = 0; i < 8; i++) cyc("drain2", 1'b0, 1'b1, 1'b0);
        chk_state("drain2", 3, 3, 0, 1'b0, 1'b1, EXP_ERR);
        cyc("empty_pp", 1'b1, 1'b1, 1'b1);
        chk_state("empty_pp", 3, 4, 1, 1'b0, 1'b0, EXP_ERR);

        // Grow to 5 entries, then reset mid-stream with a push pending.
        for (int i = 0; i < 4; i++) cyc("grow", 1'b1, 1'b0, 1'b1);
        chk_state("grow", 3, 0, 5, 1'b0, 1'b0, EXP_ERR);
        reset     = 1'b1;
        q_if.push = 1'b1;
        #1;
        chk("rst_mid.wr_en", 32'(q_if.wr_en), 32'(0));
        @(posedge clk);
        #1;
        reset     = 1'b0;
        q_if.push = 1'b0;
        chk_state("rst_mid", 0, 0, 0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
